// File: rtl/lif_neuron_array.sv
// lif_neuron_array: N leaky integrate-and-fire neurons advanced together by a
// step strobe, with shared threshold/leak/refractory settings.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   step                advance every neuron by one time step this cycle
//   input_current       per-neuron current, neuron i at [i*DATA_W +: DATA_W]
//   threshold           firing threshold (fires when v >= threshold)
//   leak                subtractive amount (mode 0) or shift amount (mode 1)
//   leak_mode           0 = subtractive leak, 1 = proportional leak (v >> shift)
//   refractory_period   steps a neuron is held inactive after it spikes
//   clear_count         zero the aggregate counter (this cycle's spikes still add)
//   spike               registered one-cycle spike pulse per neuron
//   voltage             registered membrane voltage per neuron
//   spike_total         saturating count of all spikes since reset or clear
module lif_neuron_array #(
    parameter int N       = 4,
    parameter int DATA_W  = 8,
    parameter int REF_W   = 6,
    parameter int CNT_W   = 16,
    parameter int RESET_V = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step,
    input  logic [N*DATA_W-1:0] input_current,
    input  logic [DATA_W-1:0]   threshold,
    input  logic [DATA_W-1:0]   leak,
    input  logic                leak_mode,
    input  logic [REF_W-1:0]    refractory_period,
    input  logic                clear_count,
    output logic [N-1:0]        spike,
    output logic [N*DATA_W-1:0] voltage,
    output logic [CNT_W-1:0]    spike_total
);

    localparam int                SH_W  = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] RST_V = DATA_W'(RESET_V);

    logic [N-1:0][DATA_W-1:0] v_q;
    logic [N-1:0][DATA_W-1:0] v_d;
    logic [N-1:0][REF_W-1:0]  r_q;
    logic [N-1:0][REF_W-1:0]  r_d;
    logic [N-1:0]             spike_q;
    logic [N-1:0]             spike_d;
    logic [CNT_W-1:0]         total_q;
    logic [CNT_W-1:0]         total_d;

    // Per-neuron integration result, valid only when the neuron is active.
    logic [N-1:0][DATA_W-1:0] vsat;
    logic [N-1:0]             active;
    logic [N-1:0]             fire;

    for (genvar g = 0; g < N; g++) begin : g_neuron
        logic [DATA_W-1:0] cur;
        logic [DATA_W-1:0] decay;
        logic [DATA_W-1:0] vl;
        logic [DATA_W:0]   vs;

        assign cur = input_current[g*DATA_W +: DATA_W];

        // Proportional mode only looks at the low bits of leak so the shift
        // can never exceed the voltage width.
        assign decay = leak_mode ? (v_q[g] >> leak[SH_W-1:0]) : leak;

        // Leak floors at zero instead of wrapping.
        assign vl = (v_q[g] > decay) ? (v_q[g] - decay) : '0;

        // One extra bit catches overflow; saturate to all ones.
        assign vs      = {1'b0, vl} + {1'b0, cur};
        assign vsat[g] = vs[DATA_W] ? '1 : vs[DATA_W-1:0];

        assign active[g] = (r_q[g] == '0);
        assign fire[g]   = active[g] && (vsat[g] >= threshold);
    end

    always_comb begin
        v_d     = v_q;
        r_d     = r_q;
        spike_d = '0;
        if (step) begin
            for (int i = 0; i < N; i++) begin
                if (!active[i]) begin
                    // Refractory: count down, hold voltage, drop current.
                    r_d[i] = r_q[i] - 1'b1;
                end else if (fire[i]) begin
                    spike_d[i] = 1'b1;
                    v_d[i]     = RST_V;
                    r_d[i]     = refractory_period;
                end else begin
                    v_d[i] = vsat[i];
                end
            end
        end
    end

    logic [CNT_W:0] pop;
    logic [CNT_W:0] base;
    logic [CNT_W:0] sum;

    // spike_d is all zero when step is low, so the counter only moves on
    // step cycles (or on a clear).
    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + {{CNT_W{1'b0}}, spike_d[i]};
        end
        base    = clear_count ? '0 : {1'b0, total_q};
        sum     = base + pop;
        total_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q     <= {N{RST_V}};
            r_q     <= '0;
            spike_q <= '0;
            total_q <= '0;
        end else begin
            v_q     <= v_d;
            r_q     <= r_d;
            spike_q <= spike_d;
            total_q <= total_d;
        end
    end

    assign spike       = spike_q;
    assign voltage     = v_q;
    assign spike_total = total_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// tb_lif_neuron_array: table-driven vectors with a scoreboard queue, plus a
// randomised section checked against a behavioural neuron model.
module tb_lif_neuron_array;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int RW = 6;

    typedef struct {
        logic          rst;
        logic          st;
        logic [31:0]   cur;
        logic [7:0]    thr;
        logic [7:0]    lk;
        logic          md;
        logic [5:0]    rp;
        logic          clr;
        logic [31:0]   ev;
        logic [3:0]    es;
        logic [15:0]   et;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          step;
    logic [31:0]   input_current;
    logic [7:0]    threshold;
    logic [7:0]    leak;
    logic          leak_mode;
    logic [5:0]    refractory_period;
    logic          clear_count;
    logic [3:0]    spike;
    logic [31:0]   voltage;
    logic [15:0]   spike_total;
    logic [3:0]    spike_s;
    logic [31:0]   voltage_s;
    logic [3:0]    spike_total_s;

    int n_vec = 0;
    int n_bad = 0;

    vec_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    lif_neuron_array #(
        .N(N), .DATA_W(DW), .REF_W(RW), .CNT_W(16), .RESET_V(0)
    ) dut (
        .clk(clk), .reset(reset), .step(step),
        .input_current(input_current), .threshold(threshold),
        .leak(leak), .leak_mode(leak_mode),
        .refractory_period(refractory_period),
        .clear_count(clear_count), .spike(spike),
        .voltage(voltage), .spike_total(spike_total)
    );

    lif_neuron_array #(
        .N(N), .DATA_W(DW), .REF_W(RW), .CNT_W(4), .RESET_V(0)
    ) dut_s (
        .clk(clk), .reset(reset), .step(step),
        .input_current(input_current), .threshold(threshold),
        .leak(leak), .leak_mode(leak_mode),
        .refractory_period(refractory_period),
        .clear_count(clear_count), .spike(spike_s),
        .voltage(voltage_s), .spike_total(spike_total_s)
    );

    function automatic vec_t mk(
        input logic rst, input logic st, input logic [31:0] cur,
        input logic [7:0] thr, input logic [7:0] lk, input logic md,
        input logic [5:0] rp, input logic clr,
        input logic [31:0] ev, input logic [3:0] es, input logic [15:0] et);
        vec_t v;
        v.rst = rst; v.st = st; v.cur = cur; v.thr = thr; v.lk = lk;
        v.md = md; v.rp = rp; v.clr = clr; v.ev = ev; v.es = es; v.et = et;
        return v;
    endfunction

    task automatic check(input string tag);
        vec_t e;
        logic [3:0] e4;
        logic bad;
        n_vec++;
        if (sb.size() == 0) begin
            $display("FAIL %s scoreboard empty", tag);
            n_bad++;
            return;
        end
        e = sb.pop_front();
        // Narrow counter saturates at 15 but otherwise tracks the wide one.
        e4 = (e.et > 16'd15) ? 4'hF : e.et[3:0];
        bad = 1'b0;
        if (voltage !== e.ev) begin
            $display("FAIL %s voltage got %h want %h", tag, voltage, e.ev);
            bad = 1'b1;
        end
        if (spike !== e.es) begin
            $display("FAIL %s spike got %b want %b", tag, spike, e.es);
            bad = 1'b1;
        end
        if (spike_total !== e.et) begin
            $display("FAIL %s spike_total got %0d want %0d",
                     tag, spike_total, e.et);
            bad = 1'b1;
        end
        if (spike_total_s !== e4) begin
            $display("FAIL %s spike_total(CNT_W=4) got %0d want %0d",
                     tag, spike_total_s, e4);
            bad = 1'b1;
        end
        if (voltage_s !== e.ev || spike_s !== e.es) begin
            $display("FAIL %s narrow-instance v/s got %h/%b want %h/%b",
                     tag, voltage_s, spike_s, e.ev, e.es);
            bad = 1'b1;
        end
        if (bad) n_bad++;
    endtask

    task automatic apply(input vec_t v, input string tag);
        reset             = v.rst;
        step              = v.st;
        input_current     = v.cur;
        threshold         = v.thr;
        leak              = v.lk;
        leak_mode         = v.md;
        refractory_period = v.rp;
        clear_count       = v.clr;
        sb.push_back(v);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    // Behavioural model for the randomised section.
    int mv[N];
    int mr[N];
    int mt;

    initial begin
        reset = 1'b1; step = 1'b0; input_current = '0; threshold = '0;
        leak = '0; leak_mode = 1'b0; refractory_period = '0;
        clear_count = 1'b0;

        // Subtractive integrate/fire on neuron 0, ref=2, then gated steps.
        tbl.push_back(mk(1,0,32'h20,8'h50,8'h08,0,6'd2,0, 32'h0,4'h0,16'd0));
        tbl.push_back(mk(0,1,32'h20,8'h50,8'h08,0,6'd2,0, 32'h20,4'h0,16'd0));
        tbl.push_back(mk(0,1,32'h20,8'h50,8'h08,0,6'd2,0, 32'h38,4'h0,16'd0));
        tbl.push_back(mk(0,1,32'h20,8'h50,8'h08,0,6'd2,0, 32'h00,4'h1,16'd1));
        tbl.push_back(mk(0,1,32'h20,8'h50,8'h08,0,6'd2,0, 32'h00,4'h0,16'd1));
        tbl.push_back(mk(0,1,32'h20,8'h50,8'h08,0,6'd2,0, 32'h00,4'h0,16'd1));
        tbl.push_back(mk(0,1,32'h20,8'h50,8'h08,0,6'd2,0, 32'h20,4'h0,16'd1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,0,32'h40404040,8'h50,8'h08,0,6'd2,0,
                             32'h20,4'h0,16'd1));
        // Saturation: 0x90+0x90 clamps to 0xFF and fires all four at once.
        tbl.push_back(mk(1,0,32'h90909090,8'hFF,8'h00,0,6'd0,0, 32'h0,4'h0,16'd0));
        tbl.push_back(mk(0,1,32'h90909090,8'hFF,8'h00,0,6'd0,0,
                         32'h90909090,4'h0,16'd0));
        tbl.push_back(mk(0,1,32'h90909090,8'hFF,8'h00,0,6'd0,0,
                         32'h0,4'hF,16'd4));
        // Proportional leak; 0x0A uses only its low bits (shift 2).
        tbl.push_back(mk(1,0,32'h40,8'hFF,8'h02,1,6'd0,0, 32'h0,4'h0,16'd0));
        tbl.push_back(mk(0,1,32'h40,8'hFF,8'h02,1,6'd0,0, 32'h40,4'h0,16'd0));
        tbl.push_back(mk(0,1,32'h40,8'hFF,8'h02,1,6'd0,0, 32'h70,4'h0,16'd0));
        tbl.push_back(mk(0,1,32'h40,8'hFF,8'h0A,1,6'd0,0, 32'h94,4'h0,16'd0));
        // Subtractive underflow floors at zero.
        tbl.push_back(mk(1,0,32'h10,8'hFF,8'h00,0,6'd0,0, 32'h0,4'h0,16'd0));
        tbl.push_back(mk(0,1,32'h10,8'hFF,8'h00,0,6'd0,0, 32'h10,4'h0,16'd0));
        tbl.push_back(mk(0,1,32'h00,8'hFF,8'h30,0,6'd0,0, 32'h00,4'h0,16'd0));
        // Counter: threshold 0 fires every step; narrow copy saturates at 15.
        tbl.push_back(mk(1,0,32'h0,8'h00,8'h00,0,6'd0,0, 32'h0,4'h0,16'd0));
        for (int i = 1; i <= 5; i++)
            tbl.push_back(mk(0,1,32'h0,8'h00,8'h00,0,6'd0,0,
                             32'h0,4'hF,16'(4*i)));
        tbl.push_back(mk(0,1,32'h0,8'h00,8'h00,0,6'd0,1, 32'h0,4'hF,16'd4));
        tbl.push_back(mk(0,0,32'h0,8'h00,8'h00,0,6'd0,1, 32'h0,4'h0,16'd0));
        tbl.push_back(mk(0,1,32'h0,8'h00,8'h00,0,6'd0,0, 32'h0,4'hF,16'd4));
        // Reset one cycle after a spike with ref=5 leaves no refractory.
        tbl.push_back(mk(1,0,32'h20,8'h10,8'h00,0,6'd5,0, 32'h0,4'h0,16'd0));
        tbl.push_back(mk(0,1,32'h20,8'h10,8'h00,0,6'd5,0, 32'h0,4'h1,16'd1));
        tbl.push_back(mk(1,1,32'h20,8'h10,8'h00,0,6'd5,1, 32'h0,4'h0,16'd0));
        tbl.push_back(mk(0,1,32'h08,8'h10,8'h00,0,6'd5,0, 32'h08,4'h0,16'd0));
        tbl.push_back(mk(0,1,32'h08,8'h10,8'h00,0,6'd5,0, 32'h00,4'h1,16'd1));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // Randomised independent-neuron run against the model.
        apply(mk(1,0,32'h0,8'h00,8'h00,0,6'd0,0, 32'h0,4'h0,16'd0), "rnd_rst");
        for (int i = 0; i < N; i++) begin
            mv[i] = 0;
            mr[i] = 0;
        end
        mt = 0;
        for (int k = 0; k < 60; k++) begin
            vec_t v;
            int pop;
            int base;
            v.rst = 1'b0;
            v.st  = ($urandom_range(0, 3) != 0);
            v.cur = $urandom;
            v.thr = 8'($urandom_range(64, 255));
            v.lk  = 8'($urandom_range(0, 40));
            v.md  = 1'($urandom_range(0, 1));
            v.rp  = 6'($urandom_range(0, 3));
            v.clr = ($urandom_range(0, 7) == 0);
            v.es  = '0;
            pop = 0;
            for (int i = 0; i < N; i++) begin
                if (v.st) begin
                    if (mr[i] > 0) begin
                        mr[i] = mr[i] - 1;
                    end else begin
                        int dec;
                        int vl;
                        int vs;
                        dec = v.md ? (mv[i] >> (int'(v.lk) % 8)) : int'(v.lk);
                        vl  = (mv[i] > dec) ? mv[i] - dec : 0;
                        vs  = vl + int'(v.cur[i*8 +: 8]);
                        if (vs > 255) vs = 255;
                        if (vs >= int'(v.thr)) begin
                            v.es[i] = 1'b1;
                            pop++;
                            mv[i] = 0;
                            mr[i] = int'(v.rp);
                        end else begin
                            mv[i] = vs;
                        end
                    end
                end
                v.ev[i*8 +: 8] = 8'(mv[i]);
            end
            base = v.clr ? 0 : mt;
            mt = base + pop;
            if (mt > 65535) mt = 65535;
            v.et = 16'(mt);
            apply(v, $sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
